// File: rtl/pc_pkg.sv
// =====================================================================
// Module   : pc_pkg
// Brief    : Redirect opcode encoding shared by the PC sequencer.
// Revision : 1.0
// =====================================================================
`default_nettype none

package pc_pkg;

   localparam int PC_OP_W = 3;

   typedef enum logic [PC_OP_W-1:0] {
      PC_OP_NONE   = 3'd0,
      PC_OP_JUMP   = 3'd1,
      PC_OP_BRANCH = 3'd2,
      PC_OP_CALL   = 3'd3,
      PC_OP_RET    = 3'd4
   } pc_op_e;

endpackage

`default_nettype wire

// File: rtl/pc_seq_if.sv
// =====================================================================
// Module   : pc_seq_if
// Brief    : Redirect/stall request bundle and fetch-address/RAS status.
// Revision : 1.0
// =====================================================================
`default_nettype none

interface pc_seq_if #(
   parameter int WIDTH = 8
);
   import pc_pkg::*;

   logic                 stall_i;
   logic [PC_OP_W-1:0]   op_i;
   logic [WIDTH-1:0]     target_i;
   logic                 err_clr_i;
   logic [WIDTH-1:0]     pc_o;
   logic                 ras_empty_o;
   logic                 ras_full_o;
   logic                 ras_err_o;

   modport master (
      output stall_i, op_i, target_i, err_clr_i,
      input  pc_o, ras_empty_o, ras_full_o, ras_err_o
   );

   modport slave (
      input  stall_i, op_i, target_i, err_clr_i,
      output pc_o, ras_empty_o, ras_full_o, ras_err_o
   );

endinterface

`default_nettype wire

// File: rtl/pc_ras.sv
// =====================================================================
// Module   : pc_ras
// Brief    : Circular LIFO return-address stack; overwrites oldest on full.
// Revision : 1.0
// =====================================================================
`default_nettype none

module pc_ras #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             ovf_o,
   output logic             unf_o
);
   import pc_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] top_q, top_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] wr_ptr;
   logic             wr_en;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_FULL);
   assign ovf_o   = push_i & full_o;
   assign unf_o   = pop_i & ~push_i & empty_o;
   assign data_o  = mem_q[top_q];

   // Pushing when full lands on the oldest slot: the pointer wraps into it.
   always_comb begin
      top_d  = top_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_ptr = top_q + PTR_W'(1);
      if (push_i) begin
         wr_en = 1'b1;
         top_d = wr_ptr;
         if (!full_o) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (pop_i && !empty_o) begin
         top_d = top_q - PTR_W'(1);
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr] <= data_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_seq.sv
// =====================================================================
// Module   : pc_seq
// Brief    : Fetch PC sequencer: step, stall, jump, branch, call/return.
//            Return-address stack compiled in when PC_SEQ_RAS_EN is defined.
// Revision : 1.0
// =====================================================================
`default_nettype none

module pc_seq #(
   parameter int WIDTH     = 8,
   parameter int STEP      = 2,
   parameter int RESET_VEC = 0,
   parameter int RAS_DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_n_i,
   pc_seq_if.slave  bus
);
   import pc_pkg::*;

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] seq_pc;

   assign seq_pc = bus.stall_i ? pc_q : pc_q + STEP_W;

`ifdef PC_SEQ_RAS_EN
   logic             push_req;
   logic             pop_req;
   logic [WIDTH-1:0] ras_top;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_ovf;
   logic             ras_unf;
   logic             err_q, err_d;

   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push_req),
      .pop_i   (pop_req),
      .data_i  (pc_q + STEP_W),
      .data_o  (ras_top),
      .empty_o (ras_empty),
      .full_o  (ras_full),
      .ovf_o   (ras_ovf),
      .unf_o   (ras_unf)
   );
`endif

   always_comb begin
      pc_d = seq_pc;
`ifdef PC_SEQ_RAS_EN
      push_req = 1'b0;
      pop_req  = 1'b0;
`endif
      case (pc_op_e'(bus.op_i))
         PC_OP_JUMP:   pc_d = bus.target_i;
         PC_OP_BRANCH: pc_d = pc_q + bus.target_i;
         PC_OP_CALL: begin
            pc_d = bus.target_i;
`ifdef PC_SEQ_RAS_EN
            push_req = 1'b1;
`endif
         end
         PC_OP_RET: begin
`ifdef PC_SEQ_RAS_EN
            // An empty-stack return falls through to the sequential PC.
            pop_req = 1'b1;
            if (!ras_empty) begin
               pc_d = ras_top;
            end
`else
            pc_d = seq_pc;
`endif
         end
         default:      pc_d = seq_pc;
      endcase
   end

`ifdef PC_SEQ_RAS_EN
   always_comb begin
      err_d = err_q;
      if (ras_ovf || ras_unf) begin
         err_d = 1'b1;
      end else if (bus.err_clr_i) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.ras_empty_o = ras_empty;
   assign bus.ras_full_o  = ras_full;
   assign bus.ras_err_o   = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr  = bus.err_clr_i;
   assign bus.ras_empty_o = 1'b1;
   assign bus.ras_full_o  = 1'b0;
   assign bus.ras_err_o   = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q <= RST_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign bus.pc_o = pc_q;

endmodule

`default_nettype wire
